// File: rtl/tff_bank_ctrl.sv
// tff_bank_ctrl: T flip-flop bank whose toggle enables are sequenced by a CLEAR/LOAD/UP/DOWN command FSM.
module tff_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_q, r_data, r_rem, w_up, w_dn, w_t;
  logic [1:0]       r_op;
  logic             w_acc, w_zero;
  assign w_up[0] = 1'b1;
  assign w_dn[0] = 1'b1;
  genvar i;
  for (i = 1; i < WIDTH; i++) begin : g_pfx
    assign w_up[i] = &r_q[i-1:0];
    assign w_dn[i] = ~|r_q[i-1:0];
  end
  always_comb begin
    w_acc  = start && (r_state != RUN);
    w_zero = op[1] && (data == '0);
    w_nxt  = (r_state == RUN) ? ((r_rem == WIDTH'(1)) ? DONE : RUN)
           : w_acc ? (w_zero ? DONE : RUN) : IDLE;
    w_t    = (r_state != RUN) ? '0
           : (r_op == 2'b00) ? r_q
           : (r_op == 2'b01) ? (r_q ^ r_data)
           : (r_op == 2'b10) ? w_up : w_dn;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_nxt;
      r_q     <= r_q ^ w_t;
      if (w_acc) begin
        r_op   <= op;
        r_data <= data;
        r_rem  <= op[1] ? data : WIDTH'(1);
      end else if (r_state == RUN) begin
        r_rem  <= r_rem - WIDTH'(1);
      end
    end
  end
  assign t_vec = w_t;
  assign q     = r_q;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
endmodule
